// File: rtl/mc_ctrl_fsm_if.sv
// Shared instruction/data memory port between the multi-cycle controller and memory.
// The controller is the master: it raises mem_req with a stable address select and write flag until mem_ready.
interface mc_ctrl_fsm_if;
  logic mem_req;
  logic mem_we;
  logic IorD;
  logic mem_ready;

  modport master (output mem_req, output mem_we, output IorD, input mem_ready);
  modport slave  (input mem_req, input mem_we, input IorD, output mem_ready);
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS-subset controller: FETCH/DECODE/EXEC/MEM/WB sequencing over one shared memory port,
// datapath select decode, PC/IR write strobes and a retired-instruction counter.
//
// state  | meaning
// FETCH  | request instruction at PC, load IR on mem_ready
// DECODE | classify IR; illegal Op/Funct skips to next PC
// EXEC   | ALU step; branches/jumps retire here
// MEM    | lw/sw data access at ALU address, held until mem_ready
// WB     | register write-back and PC advance
module mc_ctrl_fsm #(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [5:0]       Op,
  input  logic [5:0]       Funct,
  input  logic             Zero,
  mc_ctrl_fsm_if.master    mem,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             RegWrite,
  output logic [3:0]       ALUOp,
  output logic [1:0]       NPCOp,
  output logic             ALUSrc,
  output logic [1:0]       ALUSrcA,
  output logic             EXTOp,
  output logic [1:0]       GPRSel,
  output logic [1:0]       WDSel,
  output logic [2:0]       state,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_e;

  typedef enum logic [2:0] {C_ALU, C_LW, C_SW, C_BR, C_JMP, C_LINK} cls_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  logic       dec_valid, is_bne;
  cls_e       dec_cls;
  logic [3:0] alu_op;
  logic       alu_src, ext_op;
  logic [1:0] alu_src_a, gpr_sel, wd_sel, npc_sel;
  logic       rdy, sel_en;
  logic       req_c, we_c, iord_c, irw_c, pcw_c, rgw_c, ill_c;

  assign rdy = MEM_HANDSHAKE ? mem.mem_ready : 1'b1;

  always_comb begin
    dec_valid = 1'b1;
    dec_cls   = C_ALU;
    is_bne    = 1'b0;
    alu_op    = 4'h0;
    alu_src   = 1'b0;
    alu_src_a = 2'b00;
    ext_op    = 1'b0;
    gpr_sel   = 2'b00;
    wd_sel    = 2'b00;
    npc_sel   = 2'b00;
    case (Op)
      6'h00: begin
        case (Funct)
          6'h20, 6'h21: alu_op = 4'h1;
          6'h22, 6'h23: alu_op = 4'h2;
          6'h24: alu_op = 4'h3;
          6'h25: alu_op = 4'h4;
          6'h27: alu_op = 4'h8;
          6'h2A: alu_op = 4'h5;
          6'h2B: alu_op = 4'h6;
          6'h00: begin alu_op = 4'hA; alu_src_a = 2'b01; end
          6'h02: begin alu_op = 4'hB; alu_src_a = 2'b01; end
          6'h04: begin alu_op = 4'hA; alu_src_a = 2'b10; end
          6'h06: begin alu_op = 4'hB; alu_src_a = 2'b10; end
          6'h08: begin dec_cls = C_JMP; npc_sel = 2'b11; end
          6'h09: begin dec_cls = C_LINK; npc_sel = 2'b11; wd_sel = 2'b10; end
          default: dec_valid = 1'b0;
        endcase
      end
      6'h08: begin alu_op = 4'h1; alu_src = 1'b1; ext_op = 1'b1; gpr_sel = 2'b01; end
      6'h0C: begin alu_op = 4'h3; alu_src = 1'b1; gpr_sel = 2'b01; end
      6'h0D: begin alu_op = 4'h4; alu_src = 1'b1; gpr_sel = 2'b01; end
      6'h0A: begin alu_op = 4'h5; alu_src = 1'b1; ext_op = 1'b1; gpr_sel = 2'b01; end
      6'h0F: begin alu_op = 4'h9; alu_src = 1'b1; gpr_sel = 2'b01; end
      6'h23: begin
        dec_cls = C_LW; alu_op = 4'h1; alu_src = 1'b1; ext_op = 1'b1;
        gpr_sel = 2'b01; wd_sel = 2'b01;
      end
      6'h2B: begin dec_cls = C_SW; alu_op = 4'h1; alu_src = 1'b1; ext_op = 1'b1; gpr_sel = 2'b01; end
      6'h04: begin dec_cls = C_BR; alu_op = 4'h2; ext_op = 1'b1; end
      6'h05: begin dec_cls = C_BR; alu_op = 4'h2; ext_op = 1'b1; is_bne = 1'b1; end
      6'h02: begin dec_cls = C_JMP; npc_sel = 2'b10; end
      6'h03: begin dec_cls = C_LINK; npc_sel = 2'b10; gpr_sel = 2'b10; wd_sel = 2'b10; end
      default: dec_valid = 1'b0;
    endcase
    // beq takes on Zero, bne on ~Zero
    if (dec_cls == C_BR) npc_sel = {1'b0, Zero ^ is_bne};
  end

  always_comb begin
    state_d = state_q;
    req_c   = 1'b0;
    we_c    = 1'b0;
    iord_c  = 1'b0;
    irw_c   = 1'b0;
    pcw_c   = 1'b0;
    rgw_c   = 1'b0;
    ill_c   = 1'b0;
    case (state_q)
      S_FETCH: begin
        req_c = 1'b1;
        if (rdy) begin
          irw_c   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (dec_valid) state_d = S_EXEC;
        else begin
          ill_c   = 1'b1;
          pcw_c   = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXEC: begin
        case (dec_cls)
          C_LW, C_SW:   state_d = S_MEM;
          C_BR, C_JMP: begin pcw_c = 1'b1; state_d = S_FETCH; end
          C_LINK:      begin pcw_c = 1'b1; rgw_c = 1'b1; state_d = S_FETCH; end
          default:     state_d = S_WB;
        endcase
      end
      S_MEM: begin
        req_c  = 1'b1;
        iord_c = 1'b1;
        we_c   = (dec_cls == C_SW);
        if (rdy) begin
          if (dec_cls == C_SW) begin
            pcw_c   = 1'b1;
            state_d = S_FETCH;
          end else state_d = S_WB;
        end
      end
      S_WB: begin
        rgw_c   = 1'b1;
        pcw_c   = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // State already resets to FETCH; rstn gating keeps the FETCH request quiet while reset is held.
  assign mem.mem_req = req_c & rstn;
  assign mem.mem_we  = we_c & rstn;
  assign mem.IorD    = iord_c & rstn;
  assign IRWrite     = irw_c & rstn;
  assign PCWrite     = pcw_c & rstn;
  assign RegWrite    = rgw_c & rstn;
  assign illegal     = ill_c & rstn;

  assign sel_en  = rstn & (state_q != S_FETCH);
  assign ALUOp   = sel_en ? alu_op    : 4'h0;
  assign NPCOp   = sel_en ? npc_sel   : 2'b00;
  assign ALUSrc  = sel_en & alu_src;
  assign ALUSrcA = sel_en ? alu_src_a : 2'b00;
  assign EXTOp   = sel_en & ext_op;
  assign GPRSel  = sel_en ? gpr_sel   : 2'b00;
  assign WDSel   = sel_en ? wd_sel    : 2'b00;

  assign instret_d = PCWrite ? instret_q + CNT_W'(1) : instret_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  assign state   = state_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: directed scenarios plus random instruction mix, each instruction
// expanded into an expected per-cycle trace from the controller's cycle rules.
module tb_mc_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [5:0]  Op = 6'h0, Funct = 6'h0;
  logic        Zero = 1'b0;
  logic        IRWrite, PCWrite, RegWrite, ALUSrc, EXTOp, illegal;
  logic [3:0]  ALUOp;
  logic [1:0]  NPCOp, ALUSrcA, GPRSel, WDSel;
  logic [2:0]  state;
  logic [31:0] instret;

  mc_ctrl_fsm_if mif ();

  mc_ctrl_fsm #(.MEM_HANDSHAKE(1'b1), .CNT_W(32)) dut (
    .clk(clk), .rstn(rstn), .Op(Op), .Funct(Funct), .Zero(Zero), .mem(mif.master),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite), .ALUOp(ALUOp), .NPCOp(NPCOp),
    .ALUSrc(ALUSrc), .ALUSrcA(ALUSrcA), .EXTOp(EXTOp), .GPRSel(GPRSel), .WDSel(WDSel),
    .state(state), .illegal(illegal), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef enum int {K_ALU, K_LW, K_SW, K_BEQ, K_BNE, K_J, K_JR, K_JAL, K_JALR, K_ILL} kind_e;
  typedef struct {
    logic [5:0] op; logic [5:0] funct; kind_e kind;
    logic [3:0] aluop; logic src; logic [1:0] srca; logic ext; logic [1:0] gpr; logic [1:0] wd;
  } ent_t;
  typedef struct { logic [2:0] st; bit rdy; logic [6:0] strb; } cyc_t;

  // strobe vector order: mem_req, mem_we, IorD, IRWrite, PCWrite, RegWrite, illegal
  localparam logic [6:0] REQ = 7'b1000000, WE = 7'b0100000, IOD = 7'b0010000, IRW = 7'b0001000;
  localparam logic [6:0] PCW = 7'b0000100, RGW = 7'b0000010, ILL = 7'b0000001;

  ent_t        tbl[$];
  int          tests = 0, fails = 0;
  logic [31:0] model_cnt = 32'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic cyc_t mk(input logic [2:0] st, input bit rdy, input logic [6:0] strb);
    cyc_t c; c.st = st; c.rdy = rdy; c.strb = strb; return c;
  endfunction

  function automatic int find(input logic [5:0] op, input logic [5:0] fn);
    for (int i = 0; i < tbl.size(); i++)
      if (tbl[i].op == op && (op != 6'h00 || tbl[i].funct == fn)) return i;
    return -1;
  endfunction

  task automatic run_instr(input int idx, input int fw, input int mw, input bit z, input int abort_at);
    cyc_t q[$];
    ent_t e;
    logic [1:0] npc;
    e = tbl[idx];
    for (int i = 0; i < fw; i++) q.push_back(mk(3'd0, 0, REQ));
    q.push_back(mk(3'd0, 1, REQ | IRW));
    if (e.kind == K_ILL) q.push_back(mk(3'd1, 0, PCW | ILL));
    else begin
      q.push_back(mk(3'd1, 0, 7'b0));
      case (e.kind)
        K_ALU: begin q.push_back(mk(3'd2, 0, 7'b0)); q.push_back(mk(3'd4, 0, RGW | PCW)); end
        K_LW: begin
          q.push_back(mk(3'd2, 0, 7'b0));
          for (int i = 0; i < mw; i++) q.push_back(mk(3'd3, 0, REQ | IOD));
          q.push_back(mk(3'd3, 1, REQ | IOD));
          q.push_back(mk(3'd4, 0, RGW | PCW));
        end
        K_SW: begin
          q.push_back(mk(3'd2, 0, 7'b0));
          for (int i = 0; i < mw; i++) q.push_back(mk(3'd3, 0, REQ | WE | IOD));
          q.push_back(mk(3'd3, 1, REQ | WE | IOD | PCW));
        end
        K_JAL, K_JALR: q.push_back(mk(3'd2, 0, PCW | RGW));
        default: q.push_back(mk(3'd2, 0, PCW));
      endcase
    end
    case (e.kind)
      K_BEQ: npc = z ? 2'b01 : 2'b00;
      K_BNE: npc = z ? 2'b00 : 2'b01;
      K_J, K_JAL: npc = 2'b10;
      K_JR, K_JALR: npc = 2'b11;
      default: npc = 2'b00;
    endcase
    Op = e.op; Funct = e.funct; Zero = z;
    for (int i = 0; i < q.size(); i++) begin
      mif.mem_ready = q[i].rdy;
      @(negedge clk);
      chk($sformatf("state op=%h fn=%h cyc%0d", e.op, e.funct, i), {29'd0, state}, {29'd0, q[i].st});
      chk($sformatf("strobes op=%h fn=%h cyc%0d", e.op, e.funct, i),
          {25'd0, mif.mem_req, mif.mem_we, mif.IorD, IRWrite, PCWrite, RegWrite, illegal},
          {25'd0, q[i].strb});
      if (q[i].st == 3'd2) begin
        chk($sformatf("exec_sel op=%h fn=%h", e.op, e.funct),
            {19'd0, ALUOp, ALUSrc, ALUSrcA, EXTOp, GPRSel, WDSel},
            {19'd0, e.aluop, e.src, e.srca, e.ext, e.gpr, e.wd});
        chk($sformatf("exec_npc op=%h fn=%h z=%0d", e.op, e.funct, z), {30'd0, NPCOp}, {30'd0, npc});
      end
      if (q[i].st == 3'd4 || (q[i].st == 3'd1 && e.kind == K_ILL))
        chk($sformatf("npc00 op=%h st=%0d", e.op, q[i].st), {30'd0, NPCOp}, 32'd0);
      if (q[i].st == 3'd4)
        chk($sformatf("wb_wd op=%h", e.op), {30'd0, WDSel}, {30'd0, e.wd});
      if (i == abort_at) begin
        #2 rstn = 1'b0;
        #1;
        chk("abort_strobes", {25'd0, mif.mem_req, mif.mem_we, mif.IorD, IRWrite, PCWrite, RegWrite, illegal}, 32'd0);
        chk("abort_state", {29'd0, state}, 32'd0);
        chk("abort_instret", instret, 32'd0);
        model_cnt = 32'd0;
        return;
      end
      @(posedge clk);
      #1;
    end
    model_cnt = model_cnt + 32'd1;
    chk($sformatf("instret op=%h", e.op), instret, model_cnt);
  endtask

  initial begin
    int k;
    // op funct kind aluop src srca ext gpr wd
    tbl.push_back('{6'h00, 6'h21, K_ALU, 4'h1, 0, 2'd0, 0, 2'd0, 2'd0});
    tbl.push_back('{6'h00, 6'h20, K_ALU, 4'h1, 0, 2'd0, 0, 2'd0, 2'd0});
    tbl.push_back('{6'h00, 6'h22, K_ALU, 4'h2, 0, 2'd0, 0, 2'd0, 2'd0});
    tbl.push_back('{6'h00, 6'h23, K_ALU, 4'h2, 0, 2'd0, 0, 2'd0, 2'd0});
    tbl.push_back('{6'h00, 6'h24, K_ALU, 4'h3, 0, 2'd0, 0, 2'd0, 2'd0});
    tbl.push_back('{6'h00, 6'h25, K_ALU, 4'h4, 0, 2'd0, 0, 2'd0, 2'd0});
    tbl.push_back('{6'h00, 6'h27, K_ALU, 4'h8, 0, 2'd0, 0, 2'd0, 2'd0});
    tbl.push_back('{6'h00, 6'h2A, K_ALU, 4'h5, 0, 2'd0, 0, 2'd0, 2'd0});
    tbl.push_back('{6'h00, 6'h2B, K_ALU, 4'h6, 0, 2'd0, 0, 2'd0, 2'd0});
    tbl.push_back('{6'h00, 6'h00, K_ALU, 4'hA, 0, 2'd1, 0, 2'd0, 2'd0});
    tbl.push_back('{6'h00, 6'h02, K_ALU, 4'hB, 0, 2'd1, 0, 2'd0, 2'd0});
    tbl.push_back('{6'h00, 6'h04, K_ALU, 4'hA, 0, 2'd2, 0, 2'd0, 2'd0});
    tbl.push_back('{6'h00, 6'h06, K_ALU, 4'hB, 0, 2'd2, 0, 2'd0, 2'd0});
    tbl.push_back('{6'h00, 6'h08, K_JR,   4'h0, 0, 2'd0, 0, 2'd0, 2'd0});
    tbl.push_back('{6'h00, 6'h09, K_JALR, 4'h0, 0, 2'd0, 0, 2'd0, 2'd2});
    tbl.push_back('{6'h08, 6'h15, K_ALU, 4'h1, 1, 2'd0, 1, 2'd1, 2'd0});
    tbl.push_back('{6'h0C, 6'h01, K_ALU, 4'h3, 1, 2'd0, 0, 2'd1, 2'd0});
    tbl.push_back('{6'h0D, 6'h3F, K_ALU, 4'h4, 1, 2'd0, 0, 2'd1, 2'd0});
    tbl.push_back('{6'h0A, 6'h00, K_ALU, 4'h5, 1, 2'd0, 1, 2'd1, 2'd0});
    tbl.push_back('{6'h0F, 6'h2A, K_ALU, 4'h9, 1, 2'd0, 0, 2'd1, 2'd0});
    tbl.push_back('{6'h23, 6'h04, K_LW,  4'h1, 1, 2'd0, 1, 2'd1, 2'd1});
    tbl.push_back('{6'h2B, 6'h10, K_SW,  4'h1, 1, 2'd0, 1, 2'd1, 2'd0});
    tbl.push_back('{6'h04, 6'h00, K_BEQ, 4'h2, 0, 2'd0, 1, 2'd0, 2'd0});
    tbl.push_back('{6'h05, 6'h00, K_BNE, 4'h2, 0, 2'd0, 1, 2'd0, 2'd0});
    tbl.push_back('{6'h02, 6'h08, K_J,   4'h0, 0, 2'd0, 0, 2'd0, 2'd0});
    tbl.push_back('{6'h03, 6'h09, K_JAL, 4'h0, 0, 2'd0, 0, 2'd2, 2'd2});
    tbl.push_back('{6'h3F, 6'h00, K_ILL, 4'h0, 0, 2'd0, 0, 2'd0, 2'd0});
    tbl.push_back('{6'h00, 6'h3F, K_ILL, 4'h0, 0, 2'd0, 0, 2'd0, 2'd0});
    tbl.push_back('{6'h11, 6'h21, K_ILL, 4'h0, 0, 2'd0, 0, 2'd0, 2'd0});

    // Reset with a decodable lw on Op: everything must still read zero.
    mif.mem_ready = 1'b1;
    Op = 6'h23;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_strobes", {25'd0, mif.mem_req, mif.mem_we, mif.IorD, IRWrite, PCWrite, RegWrite, illegal}, 32'd0);
    chk("rst_state", {29'd0, state}, 32'd0);
    chk("rst_instret", instret, 32'd0);
    chk("rst_selects", {16'd0, ALUOp, NPCOp, ALUSrc, ALUSrcA, EXTOp, GPRSel, WDSel}, 32'd0);
    @(posedge clk);
    #1 rstn = 1'b1;

    run_instr(find(6'h00, 6'h21), 0, 0, 1'b0, -1);
    run_instr(find(6'h23, 6'h00), 0, 3, 1'b0, -1);
    run_instr(find(6'h04, 6'h00), 0, 0, 1'b1, -1);
    run_instr(find(6'h04, 6'h00), 0, 0, 1'b0, -1);
    run_instr(find(6'h05, 6'h00), 0, 0, 1'b1, -1);
    run_instr(find(6'h05, 6'h00), 0, 0, 1'b0, -1);
    run_instr(find(6'h03, 6'h00), 0, 0, 1'b0, -1);
    run_instr(find(6'h00, 6'h08), 0, 0, 1'b0, -1);
    run_instr(find(6'h3F, 6'h00), 0, 0, 1'b0, -1);
    run_instr(find(6'h2B, 6'h00), 2, 1, 1'b0, -1);

    for (int n = 0; n < 80; n++) begin
      k = int'($urandom_range(tbl.size() - 1, 0));
      run_instr(k, int'($urandom_range(2, 0)), int'($urandom_range(3, 0)), 1'($urandom), -1);
    end

    // sw with long memory wait, reset pulled in the second MEM wait cycle (trace index 4)
    run_instr(find(6'h2B, 6'h00), 0, 5, 1'b0, 4);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    run_instr(find(6'h00, 6'h25), 0, 0, 1'b0, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
